// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking classifier.
package snn_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam int THRESHOLD_DEF     = 16;
   localparam int THRESHOLD_INC_DEF = 2;
   localparam int THRESHOLD_DEC_DEF = 1;
   localparam int THRESHOLD_MIN_DEF = 8;
   localparam int THRESHOLD_MAX_DEF = 255;

   function automatic int addr_w(int ni, int nh, int no);
      return $clog2(ni * nh + nh * no);
   endfunction

   // Full-width sum of n weights, so no synaptic current is ever truncated.
   function automatic int cur_w(int ww, int n);
      return ww + $clog2(n + 1);
   endfunction

   function automatic int sel_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snn_classifier_lif_neuron.sv
// Leaky integrate-and-fire neuron with an adaptive threshold and a registered spike.
module lif_neuron #(
   parameter int POT_W         = 8,
   parameter int CUR_W         = 6,
   parameter int THRESHOLD     = 16,
   parameter int THRESHOLD_INC = 2,
   parameter int THRESHOLD_DEC = 1,
   parameter int THRESHOLD_MIN = 8,
   parameter int THRESHOLD_MAX = 255,
   parameter int LEAK_SHIFT    = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [CUR_W-1:0] cur_i,
   output logic             spike_o
);
   localparam int SW = ((POT_W > CUR_W) ? POT_W : CUR_W) + 1;
   localparam logic [SW-1:0] PMAX = SW'((1 << POT_W) - 1);

   logic [POT_W-1:0] v, thr, s, leaked, thr_up, thr_dn;
   logic [SW-1:0]    sum;
   logic [POT_W:0]   up_raw;

   always_comb begin
      sum    = SW'(v) + SW'(cur_i);
      s      = (sum > PMAX) ? PMAX[POT_W-1:0] : sum[POT_W-1:0];
      // A shift of zero means no leak, not a full discharge.
      leaked = (LEAK_SHIFT == 0) ? s : s - (s >> LEAK_SHIFT);
      up_raw = {1'b0, thr} + (POT_W+1)'(THRESHOLD_INC);
      thr_up = (up_raw > (POT_W+1)'(THRESHOLD_MAX)) ? POT_W'(THRESHOLD_MAX) : up_raw[POT_W-1:0];
      thr_dn = ({1'b0, thr} >= (POT_W+1)'(THRESHOLD_MIN + THRESHOLD_DEC))
               ? thr - POT_W'(THRESHOLD_DEC) : POT_W'(THRESHOLD_MIN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v       <= '0;
         thr     <= POT_W'(THRESHOLD);
         spike_o <= 1'b0;
      end else if (clr_i) begin
         v       <= '0;
         thr     <= POT_W'(THRESHOLD);
         spike_o <= 1'b0;
      end else if (en_i) begin
         if (s >= thr) begin
            spike_o <= 1'b1;
            v       <= '0;
            thr     <= thr_up;
         end else begin
            spike_o <= 1'b0;
            v       <= leaked;
            thr     <= thr_dn;
         end
      end
   end

endmodule

// File: rtl/snn_classifier.sv
// Two-layer spiking classifier: windowed run, output spike counting, argmax class.
module snn_classifier
   import snn_pkg::*;
#(
   parameter int NUM_IN        = 8,
   parameter int NUM_HIDDEN    = 3,
   parameter int NUM_OUT       = 10,
   parameter int WEIGHT_W      = 3,
   parameter int POT_W         = 8,
   parameter int CNT_W         = 8,
   parameter int WINDOW        = 64,
   parameter int THRESHOLD     = THRESHOLD_DEF,
   parameter int THRESHOLD_INC = THRESHOLD_INC_DEF,
   parameter int THRESHOLD_DEC = THRESHOLD_DEC_DEF,
   parameter int THRESHOLD_MIN = THRESHOLD_MIN_DEF,
   parameter int THRESHOLD_MAX = THRESHOLD_MAX_DEF,
   parameter int LEAK_SHIFT    = 3,
   localparam int ADDR_W = addr_w(NUM_IN, NUM_HIDDEN, NUM_OUT),
   localparam int SEL_W  = sel_w(NUM_OUT)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NUM_IN-1:0] in_spikes_i,
   input  logic              start_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WEIGHT_W-1:0] wr_data_i,
   input  logic [SEL_W-1:0]  count_sel_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [SEL_W-1:0]  class_o,
   output logic [CNT_W-1:0]  count_o
);
   localparam int HW     = cur_w(WEIGHT_W, NUM_IN);
   localparam int OW     = cur_w(WEIGHT_W, NUM_HIDDEN);
   localparam int CYC_W  = $clog2(WINDOW + 1);
   localparam int NSYN_H = NUM_IN * NUM_HIDDEN;

   state_t state;
   logic [CYC_W-1:0] cyc;
   logic run, last, accept;
   logic [NUM_IN-1:0] in_g;
   logic [NUM_HIDDEN-1:0][NUM_IN-1:0][WEIGHT_W-1:0] w_h;
   logic [NUM_OUT-1:0][NUM_HIDDEN-1:0][WEIGHT_W-1:0] w_o;
   logic [NUM_HIDDEN-1:0][HW-1:0] cur_h;
   logic [NUM_OUT-1:0][OW-1:0]    cur_o;
   logic [NUM_HIDDEN-1:0] spk_h;
   logic [NUM_OUT-1:0]    spk_o;
   logic [NUM_OUT-1:0][CNT_W-1:0] cnt, cnt_nxt;
   logic [SEL_W-1:0] best;
   logic [CNT_W-1:0] best_cnt;

   assign run    = (state == ST_RUN);
   assign last   = run && (cyc == CYC_W'(WINDOW));
   assign accept = start_i && !run;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_h <= '0;
         w_o <= '0;
      end else if (wr_en_i && !run) begin
         for (int h = 0; h < NUM_HIDDEN; h++)
            for (int i = 0; i < NUM_IN; i++)
               if (wr_addr_i == ADDR_W'(h * NUM_IN + i)) w_h[h][i] <= wr_data_i;
         for (int o = 0; o < NUM_OUT; o++)
            for (int h = 0; h < NUM_HIDDEN; h++)
               if (wr_addr_i == ADDR_W'(NSYN_H + o * NUM_HIDDEN + h)) w_o[o][h] <= wr_data_i;
      end
   end

   // The final window cycle drains the network: inputs are gated off.
   always_comb begin
      in_g = last ? '0 : in_spikes_i;
      for (int h = 0; h < NUM_HIDDEN; h++) begin
         cur_h[h] = '0;
         for (int i = 0; i < NUM_IN; i++)
            if (in_g[i]) cur_h[h] = cur_h[h] + HW'(w_h[h][i]);
      end
      for (int o = 0; o < NUM_OUT; o++) begin
         cur_o[o] = '0;
         for (int h = 0; h < NUM_HIDDEN; h++)
            if (spk_h[h]) cur_o[o] = cur_o[o] + OW'(w_o[o][h]);
      end
   end

   for (genvar h = 0; h < NUM_HIDDEN; h++) begin : g_hid
      lif_neuron #(.POT_W(POT_W), .CUR_W(HW), .THRESHOLD(THRESHOLD),
                   .THRESHOLD_INC(THRESHOLD_INC), .THRESHOLD_DEC(THRESHOLD_DEC),
                   .THRESHOLD_MIN(THRESHOLD_MIN), .THRESHOLD_MAX(THRESHOLD_MAX),
                   .LEAK_SHIFT(LEAK_SHIFT))
      u_lif (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(run), .clr_i(accept),
             .cur_i(cur_h[h]), .spike_o(spk_h[h]));
   end

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
      lif_neuron #(.POT_W(POT_W), .CUR_W(OW), .THRESHOLD(THRESHOLD),
                   .THRESHOLD_INC(THRESHOLD_INC), .THRESHOLD_DEC(THRESHOLD_DEC),
                   .THRESHOLD_MIN(THRESHOLD_MIN), .THRESHOLD_MAX(THRESHOLD_MAX),
                   .LEAK_SHIFT(LEAK_SHIFT))
      u_lif (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(run), .clr_i(accept),
             .cur_i(cur_o[o]), .spike_o(spk_o[o]));
   end

   // Argmax looks at next-state counts so the last in-window spike is included.
   always_comb begin
      for (int o = 0; o < NUM_OUT; o++)
         cnt_nxt[o] = (spk_o[o] && cnt[o] != {CNT_W{1'b1}}) ? cnt[o] + 1'b1 : cnt[o];
      best     = '0;
      best_cnt = cnt_nxt[0];
      for (int o = 1; o < NUM_OUT; o++)
         if (cnt_nxt[o] > best_cnt) begin
            best_cnt = cnt_nxt[o];
            best     = SEL_W'(o);
         end
      count_o = '0;
      for (int o = 0; o < NUM_OUT; o++)
         if (count_sel_i == SEL_W'(o)) count_o = cnt[o];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         cyc     <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         class_o <= '0;
         cnt     <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state  <= ST_RUN;
                  cyc    <= '0;
                  busy_o <= 1'b1;
                  cnt    <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               cnt <= cnt_nxt;
               if (cyc == CYC_W'(WINDOW)) begin
                  state   <= ST_DONE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  class_o <= best;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_classifier.sv
// Window-level scoreboard bench for snn_classifier with a behavioural reference model.
module tb_snn_classifier;
   localparam int NI = 8, NH = 3, NO = 10, W = 64, LS = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_spikes = '0;
   logic       start = 1'b0;
   logic       wr_en = 1'b0;
   logic [5:0] wr_addr = '0;
   logic [2:0] wr_data = '0;
   logic [3:0] count_sel = '0;
   logic       busy, done;
   logic [3:0] class_q;
   logic [7:0] count;

   snn_classifier #(.LEAK_SHIFT(LS)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_spikes_i(in_spikes), .start_i(start),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .count_sel_i(count_sel), .busy_o(busy), .done_o(done),
      .class_o(class_q), .count_o(count));

   always #5 clk = ~clk;

   typedef struct { int cls; int cnt[NO]; } exp_t;
   typedef struct {
      int nw; logic [2:0][5:0] addr; logic [2:0][2:0] data; logic [7:0] pat; bit probe;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[5];
   int   mw_h[NH][NI];
   int   mw_o[NO][NH];
   int   checks = 0, fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic lif(input int cur, inout int v, inout int thr, output bit sp);
      int s = v + cur;
      if (s > 255) s = 255;
      if (s >= thr) begin
         sp = 1; v = 0; thr = (thr + 2 > 255) ? 255 : thr + 2;
      end else begin
         sp = 0; v = (LS == 0) ? s : s - (s >> LS); thr = (thr - 1 < 8) ? 8 : thr - 1;
      end
   endtask

   task automatic model(input logic [7:0] pat, output exp_t e);
      int vh[NH], th[NH], vo[NO], tho[NO], cur;
      bit sh[NH], so[NO], nsh[NH], nso[NO];
      for (int h = 0; h < NH; h++) begin vh[h] = 0; th[h] = 16; sh[h] = 0; end
      for (int o = 0; o < NO; o++) begin vo[o] = 0; tho[o] = 16; so[o] = 0; e.cnt[o] = 0; end
      for (int t = 0; t <= W; t++) begin
         for (int o = 0; o < NO; o++) if (so[o] && e.cnt[o] < 255) e.cnt[o]++;
         for (int h = 0; h < NH; h++) begin
            cur = 0;
            for (int i = 0; i < NI; i++) if (t != W && pat[i]) cur += mw_h[h][i];
            lif(cur, vh[h], th[h], nsh[h]);
         end
         for (int o = 0; o < NO; o++) begin
            cur = 0;
            for (int h = 0; h < NH; h++) if (sh[h]) cur += mw_o[o][h];
            lif(cur, vo[o], tho[o], nso[o]);
         end
         sh = nsh; so = nso;
      end
      e.cls = 0;
      for (int o = 1; o < NO; o++) if (e.cnt[o] > e.cnt[e.cls]) e.cls = o;
   endtask

   task automatic wr(input int a, input int d);
      @(posedge clk); #1; wr_en = 1; wr_addr = 6'(a); wr_data = 3'(d);
      @(posedge clk); #1; wr_en = 0;
      if (a < NI * NH) mw_h[a / NI][a % NI] = d;
      else if (a < NI * NH + NH * NO) mw_o[(a - NI * NH) / NH][(a - NI * NH) % NH] = d;
   endtask

   task automatic clear_w();
      for (int a = 0; a < NI * NH + NH * NO; a++) wr(a, 0);
   endtask

   task automatic run_window(input logic [7:0] pat, input bit inject, input bit probe);
      exp_t e;
      int n;
      int hits[$];
      model(pat, e);
      sb.push_back(e);
      @(posedge clk); #1; in_spikes = pat; start = 1;
      @(posedge clk); #1; start = 0; n = 1;
      while (!done && n < 300) begin
         if (probe && busy && dut.g_hid[0].u_lif.spike_o) hits.push_back(n - 1);
         if (inject && n == 20) begin start = 1; wr_en = 1; wr_addr = 6'd45; wr_data = 3'd7; end
         if (inject && n == 21) begin start = 0; wr_en = 0; end
         @(posedge clk); #1; n++;
      end
      chk("done_latency", n, W + 2);
      chk("busy_in_done", int'(busy), 0);
      e = sb.pop_front();
      chk("class", int'(class_q), e.cls);
      @(posedge clk); #1;
      chk("done_pulse_width", int'(done), 0);
      for (int o = 0; o < NO; o++) begin
         count_sel = 4'(o); #1;
         chk($sformatf("count[%0d]", o), int'(count), e.cnt[o]);
      end
      if (probe) begin
         chk("hid_spike_count_ge4", int'(hits.size() >= 4), 1);
         for (int k = 0; k < 4 && k < hits.size(); k++)
            chk($sformatf("hid_spike_time[%0d]", k), hits[k], 3 + 3 * k);
      end
      in_spikes = '0;
   endtask

   initial begin
      for (int h = 0; h < NH; h++) for (int i = 0; i < NI; i++) mw_h[h][i] = 0;
      for (int o = 0; o < NO; o++) for (int h = 0; h < NH; h++) mw_o[o][h] = 0;
      // {writes, input pattern}; expected window results come from the model
      tbl[0] = '{nw: 0, addr: '0, data: '0, pat: 8'hFF, probe: 0};
      tbl[1] = '{nw: 1, addr: {6'd0, 6'd0, 6'd0}, data: {3'd0, 3'd0, 3'd7}, pat: 8'h01, probe: 0};
      tbl[2] = '{nw: 2, addr: {6'd0, 6'd36, 6'd0}, data: {3'd0, 3'd7, 3'd7}, pat: 8'h01, probe: 1};
      tbl[3] = '{nw: 3, addr: {6'd45, 6'd30, 6'd0}, data: {3'd5, 3'd5, 3'd7}, pat: 8'h01, probe: 0};
      tbl[4] = '{nw: 3, addr: {6'd52, 6'd21, 6'd11}, data: {3'd3, 3'd6, 3'd4}, pat: 8'h28, probe: 0};

      #12; rst_n = 1'b1; #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_class", int'(class_q), 0);
      chk("rst_count0", int'(count), 0);
      count_sel = 4'd12; #1;
      chk("rst_count_sel_oor", int'(count), 0);

      for (int v = 0; v < 5; v++) begin
         if (v > 1) clear_w();
         for (int k = 0; k < tbl[v].nw; k++) wr(int'(tbl[v].addr[k]), int'(tbl[v].data[k]));
         run_window(tbl[v].pat, 1'b0, tbl[v].probe);
      end

      // Write and start during RUN are ignored; the next window confirms weight 7 unchanged
      clear_w();
      wr(0, 7); wr(36, 7);
      run_window(8'h01, 1'b1, 1'b0);
      run_window(8'h01, 1'b0, 1'b0);
      count_sel = 4'd12; #1;
      chk("count_sel_oor", int'(count), 0);

      // Reset in the middle of a window clears everything, weights included
      @(posedge clk); #1; in_spikes = 8'h01; start = 1;
      @(posedge clk); #1; start = 0;
      repeat (10) begin @(posedge clk); #1; end
      chk("midrun_busy_before", int'(busy), 1);
      rst_n = 1'b0; #1;
      chk("midrun_rst_busy", int'(busy), 0);
      chk("midrun_rst_class", int'(class_q), 0);
      count_sel = 4'd4; #1;
      chk("midrun_rst_count4", int'(count), 0);
      for (int h = 0; h < NH; h++) for (int i = 0; i < NI; i++) mw_h[h][i] = 0;
      for (int o = 0; o < NO; o++) for (int h = 0; h < NH; h++) mw_o[o][h] = 0;
      #5; rst_n = 1'b1;
      run_window(8'h01, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
      $fatal(1, "timeout");
   end

endmodule
